// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with 1024x32 data memory and writeback register
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   RegWrite_mem      register-file write enable from EX/MEM
//   MemWrite_mem      data-memory store enable
//   MemtoReg_mem      writeback select: 00 alu, 01 memory, 10 pc+8, 11 alu
//   a3_mem            destination register
//   aluout_mem        ALU result / byte address (bits [11:2] index the memory)
//   pc_mem            PC of the instruction
//   tr_b_mem          store data
//   RegWrite_wb       registered write enable (never set for $0)
//   a3_wb, wd_wb      registered destination and writeback data
//   pc_wb             registered PC
//   fwd_data_mem      combinational forwarding value (alu result or pc+8, never memory)
//   addr_err_wb       registered misaligned-access flag
//
// Optional feature: define MEM_ALIGN_CHECK_EN to enable misaligned-access
// detection; otherwise addr_err_wb is tied to 0 and address bits [1:0] are ignored.
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_mem,
  input  logic        MemWrite_mem,
  input  logic [1:0]  MemtoReg_mem,
  input  logic [4:0]  a3_mem,
  input  logic [31:0] aluout_mem,
  input  logic [31:0] pc_mem,
  input  logic [31:0] tr_b_mem,
  output logic        RegWrite_wb,
  output logic [4:0]  a3_wb,
  output logic [31:0] wd_wb,
  output logic [31:0] pc_wb,
  output logic [31:0] fwd_data_mem,
  output logic        addr_err_wb
);

  logic [31:0] mem [0:1023];
  logic [9:0]  idx;
  logic [31:0] rd_data;
  logic [31:0] pc_plus8;
  logic [31:0] wb_sel;
  logic        misaligned;
  logic        unused_addr_bits;

  // Upper address bits wrap the 4 KB space; low bits only matter for the alignment check.
  assign idx              = aluout_mem[11:2];
  assign unused_addr_bits = ^{aluout_mem[31:12], aluout_mem[1:0]};

  // Combinational read of the current contents: a same-cycle store is not yet visible.
  assign rd_data  = mem[idx];
  assign pc_plus8 = pc_mem + 32'd8;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (aluout_mem[1:0] != 2'b00) &&
                      (MemWrite_mem || (MemtoReg_mem == 2'b01));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    wb_sel = aluout_mem;
    case (MemtoReg_mem)
      2'b01:   wb_sel = rd_data;
      2'b10:   wb_sel = pc_plus8;
      default: wb_sel = aluout_mem;
    endcase
  end

  // Forwarding must not wait on the memory, so loads forward only the address.
  assign fwd_data_mem = (MemtoReg_mem == 2'b10) ? pc_plus8 : aluout_mem;

  // Reset wipes the whole array and drops any store presented in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (MemWrite_mem && !misaligned) begin
      mem[idx] <= tr_b_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite_wb <= 1'b0;
      a3_wb       <= 5'd0;
      wd_wb       <= 32'd0;
      pc_wb       <= 32'd0;
    end else begin
      RegWrite_wb <= RegWrite_mem && (a3_mem != 5'd0) && !misaligned;
      a3_wb       <= a3_mem;
      wd_wb       <= wb_sel;
      pc_wb       <= pc_mem;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err_wb <= 1'b0;
    end else begin
      addr_err_wb <= misaligned;
    end
  end
`else
  assign addr_err_wb = 1'b0;
`endif

endmodule
